// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, KPG pair codes, width.
// Also holds the KPG prefix combine operator.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] KILL = 2'b00;
  localparam logic [1:0] PROP = 2'b01;
  localparam logic [1:0] GEN  = 2'b11;

  function automatic logic [1:0] kpg_op(
    input logic [1:0] hi,
    input logic [1:0] lo
  );
    return (hi == PROP) ? lo : hi;
  endfunction

endpackage

// File: rtl/kpg_subtractor.sv
// Combinational a - b as a + ~b + 1 using a kill/propagate/generate
// prefix tree; the +1 enters as a GEN pair below bit 0.
module kpg_subtractor
  import alu_pkg::*;
#(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff
);

  localparam int S = $clog2(N + 1);

  logic [N-1:0] nb;
  logic [1:0]   lvl [0:S][0:N];

  assign nb = ~b;
  assign lvl[0][0] = GEN;

  for (genvar i = 0; i < N; i++) begin : g_pair
    assign lvl[0][i+1] = {a[i] & nb[i], a[i] | nb[i]};
  end

  for (genvar s = 0; s < S; s++) begin : g_stage
    for (genvar i = 0; i <= N; i++) begin : g_node
      if (i >= (1 << s)) begin : g_comb
        assign lvl[s+1][i] = kpg_op(lvl[s][i], lvl[s][i-(1<<s)]);
      end else begin : g_pass
        assign lvl[s+1][i] = lvl[s][i];
      end
    end
  end

  // Resolved group over positions -1..i-1 is the carry into bit i.
  for (genvar i = 0; i < N; i++) begin : g_sum
    assign diff[i] = a[i] ^ nb[i] ^ lvl[S][i][1];
  end

endmodule

// File: rtl/kpg_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, with the
// trial subtraction done by the KPG prefix subtractor.
module kpg_seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] r, q, d;
  logic [WIDTH:0] rs, diff;
  logic           accept, zero, last, keep;

  assign zero   = (divisor == '0);
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // R[WIDTH] is always 0 after a kept subtraction, so only WIDTH bits are stored.
  assign rs   = {r, q[WIDTH-1]};
  assign keep = ~diff[WIDTH];

  kpg_subtractor #(.N(WIDTH + 1)) u_sub (
    .a    (rs),
    .b    ({1'b0, d}),
    .diff (diff)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_n = zero ? DONE : RUN;
        else       state_n = IDLE;
      end
      RUN:     if (last) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt         <= '0;
      r           <= '0;
      q           <= dividend;
      d           <= divisor;
      div_by_zero <= zero;
      if (zero) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      r   <= keep ? diff[WIDTH-1:0] : rs[WIDTH-1:0];
      q   <= {q[WIDTH-2:0], keep};
      if (last) begin
        quotient  <= {q[WIDTH-2:0], keep};
        remainder <= keep ? diff[WIDTH-1:0] : rs[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_kpg_seq_divider.sv
// Directed self-checking bench for kpg_seq_divider.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_kpg_seq_divider;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  int tests = 0;
  int fails = 0;

  kpg_seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Called in cycle 1 after the start; returns done cycle and busy count.
  task automatic wait_done(output int n, output int bc);
    n  = 1;
    bc = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bc++;
      step();
      n++;
    end
    if (n >= 40) check("timeout", 32'(n), 32'd0);
  endtask

  task automatic run(input string tag, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] eq,
                     input logic [15:0] er, input logic ez,
                     input int lat);
    int n, bc;
    issue(a, b);
    wait_done(n, bc);
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_busy"}, 32'(bc), 32'(lat - 1));
    check({tag, "_q"}, 32'(quotient), 32'(eq));
    check({tag, "_r"}, 32'(remainder), 32'(er));
    check({tag, "_dz"}, 32'(div_by_zero), 32'(ez));
    step();
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    int n, bc;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);

    run("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
    run("dffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17);
    run("d5_9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 17);
    run("d8000", 16'h8000, 16'h8000, 16'd1, 16'd0, 1'b0, 17);
    run("dz", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1);

    // Start during RUN is ignored; then a back-to-back start on done.
    issue(16'd50, 16'd3);
    repeat (4) step();
    dividend = 16'd9; divisor = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    dividend = 16'd0; divisor = 16'd0;
    wait_done(n, bc);
    check("ign_lat", 32'(n), 32'd12);
    check("ign_q", 32'(quotient), 32'd16);
    check("ign_r", 32'(remainder), 32'd2);
    issue(16'd9, 16'd2);
    wait_done(n, bc);
    check("b2b_lat", 32'(n), 32'd17);
    check("b2b_q", 32'(quotient), 32'd4);
    check("b2b_r", 32'(remainder), 32'd1);
    step();

    // Reset in cycle 8 of a run aborts it.
    issue(16'd100, 16'd7);
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_q", 32'(quotient), 32'd0);
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) bc++;
      step();
    end
    check("abort_nodone", 32'(bc), 32'd0);
    run("d60_6", 16'd60, 16'd6, 16'd10, 16'd0, 1'b0, 17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
